seven_seg_scan_ctrl: RTL

//  Time-multiplexes one shared hex-to-7-segment decoder across NUM_DIGITS common-select digits.

---
 rtl/seven_seg_scan_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller that time-shares one external hex-to-7-seg decoder across NUM_DIGITS digits,
// with per-slot blanking, leading-zero suppression and frame-boundary value update.
module seven_seg_digit_gate #(
    parameter int K  = 0,
    parameter int IW = 2
) (
    input  logic [IW-1:0] idx,
    input  logic          show,
    input  logic          lz_suppress,
    input  logic          zero_here,
    output logic          lit
);
    assign lit = (idx == IW'(K)) & show & ~(lz_suppress & zero_here);
endmodule

module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    lz_suppress,
    output logic [3:0]              dec_bits,
    input  logic [6:0]              dec_seg,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_tick
);
    localparam int NW         = 4 * NUM_DIGITS;
    localparam int IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW         = $clog2(REFRESH_DIV);
    localparam int SHOW_LAST  = REFRESH_DIV - BLANK_CYCLES - 1;
    localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam int IDX_LAST   = NUM_DIGITS - 1;

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   idx, idx_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [NW-1:0]   pending, active, active_n;
    logic            fstart;
    logic            show_q;

    logic [NUM_DIGITS-1:0][3:0] act_nib;
    logic [NUM_DIGITS-1:0]      lit_vec;
    logic [NUM_DIGITS:1]        zchain;
    logic [3:0]                 dec_bits_n;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            pending    <= '0;
            active     <= '0;
            dec_bits   <= '0;
            digit_en   <= '0;
            frame_tick <= 1'b0;
            show_q     <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            active     <= active_n;
            if (load)
                pending <= value;
            // outputs are computed from next-state values so they line up with state
            dec_bits   <= dec_bits_n;
            digit_en   <= lit_vec;
            frame_tick <= fstart;
            show_q     <= |lit_vec;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        logic slot_end;
        state_n  = state;
        idx_n    = idx;
        cnt_n    = cnt;
        active_n = active;
        fstart   = 1'b0;
        slot_end = 1'b0;
        if (!en) begin
            state_n = IDLE;
            idx_n   = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n  = SHOW;
                    idx_n    = '0;
                    cnt_n    = '0;
                    active_n = pending;
                    fstart   = 1'b1;
                end
                SHOW: begin
                    if (cnt == CW'(SHOW_LAST)) begin
                        cnt_n = '0;
                        if (BLANK_CYCLES > 0) state_n  = BLANK;
                        else                  slot_end = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                BLANK: begin
                    if (cnt == CW'(BLANK_LAST)) begin
                        cnt_n    = '0;
                        slot_end = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
            endcase
            if (slot_end) begin
                state_n = SHOW;
                if (idx == IW'(IDX_LAST)) begin
                    idx_n    = '0;
                    active_n = pending;
                    fstart   = 1'b1;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
        end
    end

    // ---------------- output logic ----------------
    assign act_nib        = active_n;
    assign zchain[NUM_DIGITS] = 1'b1;

    // zchain[k] = nibbles k..top of the next active value are all zero
    genvar k;
    generate
        for (k = 0; k < NUM_DIGITS; k++) begin : g_dig
            logic zero_here;
            if (k == 0) begin : g_lsd
                assign zero_here = 1'b0;
            end else begin : g_upper
                assign zchain[k] = zchain[k+1] & (act_nib[k] == 4'h0);
                assign zero_here = zchain[k];
            end
            seven_seg_digit_gate #(.K(k), .IW(IW)) u_gate (
                .idx         (idx_n),
                .show        (state_n == SHOW),
                .lz_suppress (lz_suppress),
                .zero_here   (zero_here),
                .lit         (lit_vec[k])
            );
        end
    endgenerate

    always_comb begin
        dec_bits_n = '0;
        if (state_n != IDLE)
            dec_bits_n = act_nib[idx_n];
    end

    assign seg = dec_seg & {7{show_q}};

endmodule
